// File: rtl/fpu_issue_ctrl.sv
// Issue/response stage for the fpu core: registers operands into the FPU, tracks
// each op through the fixed FPU latency and buffers results under credit control.
module fpu_issue_ctrl #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [1:0]       req_rmode,
    input  logic [31:0]      req_opa,
    input  logic [31:0]      req_opb,
    input  logic [TAG_W-1:0] req_tag,
    output logic [2:0]       fpu_op,
    output logic [1:0]       fpu_rmode,
    output logic [31:0]      fpu_opa,
    output logic [31:0]      fpu_opb,
    input  logic [31:0]      fpu_out,
    input  logic [7:0]       fpu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [7:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             drained
);

    localparam int IW = $clog2(DEPTH);
    localparam int AW = (IW > 0) ? IW : 1;
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]      data;
        logic [7:0]       flags;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [CW-1:0]    cnt;
    logic [LAT:0]     pipe_vld;
    logic [TAG_W-1:0] pipe_tag [LAT+1];
    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             accept;
    logic             pop;
    logic             fifo_wr;
    logic             fifo_empty;

    function automatic logic [AW-1:0] idx(input logic [PW-1:0] p);
        if (DEPTH == 1) return '0;
        return AW'(p);
    endfunction

    // NOTE: req_ready is a function of cnt alone so no path runs from req_valid back to req_ready.
    assign req_ready  = (cnt != CW'(DEPTH));
    assign accept     = req_valid && req_ready;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign rsp_valid  = !fifo_empty;
    assign pop        = rsp_valid && rsp_ready;
    assign fifo_wr    = pipe_vld[LAT];
    assign drained    = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !accept) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_op    <= '0;
            fpu_rmode <= '0;
            fpu_opa   <= '0;
            fpu_opb   <= '0;
        end else if (accept) begin
            fpu_op    <= req_op;
            fpu_rmode <= req_rmode;
            fpu_opa   <= req_opa;
            fpu_opb   <= req_opb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i <= LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // NOTE: tag stages and FIFO storage carry no reset; their contents only matter behind a valid bit or pointer.
    always_ff @(posedge clk) begin
        pipe_tag[0] <= req_tag;
        for (int i = 1; i <= LAT; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[idx(wr_ptr)] <= '{data: fpu_out, flags: fpu_flags, tag: pipe_tag[LAT]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Head fields read as zero while the FIFO is empty.
    assign head      = mem[idx(rd_ptr)];
    assign rsp_data  = rsp_valid ? head.data  : '0;
    assign rsp_flags = rsp_valid ? head.flags : '0;
    assign rsp_tag   = rsp_valid ? head.tag   : '0;

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Upstream issue and response stage for the `fpu` core. It accepts floating-point operation requests over a valid/ready handshake and drives registered operands into the FPU. It tracks each operation through the FPU's fixed latency with a tag pipeline, then captures the result and its eight flags into a small response FIFO. Credit-based admission means a result never arrives with no room to store it, so the FPU itself needs no stall.

## Interface
Parameters:
- `LAT`, default 4: clock cycles from operands presented at the FPU inputs to `out`/flags valid. Equal for every op the FPU is used with.
- `DEPTH`, default 4: response FIFO entries, power of two, ≥1. It is also the maximum in-flight plus buffered operation count.
- `TAG_W`, default 4: request tag width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted.
- `req_op` in 3: passed to `fpu_op` (0 add, 1 sub, 2 mul, 3 div).
- `req_rmode` in 2: passed to `fpu_rmode`.
- `req_opa`, `req_opb` in 32: IEEE-754 single operands.
- `req_tag` in TAG_W: returned unchanged with the result.
- `fpu_op` out 3, `fpu_rmode` out 2, `fpu_opa` out 32, `fpu_opb` out 32: registered FPU inputs.
- `fpu_out` in 32: FPU result.
- `fpu_flags` in 8: {snan, qnan, inf, ine, overflow, underflow, div_by_zero, zero}, bit 7 down to bit 0.
- `rsp_valid` out 1: head of the response FIFO is valid.
- `rsp_ready` in 1: consumer takes the head.
- `rsp_data` out 32, `rsp_flags` out 8, `rsp_tag` out TAG_W: head entry.
- `drained` out 1: nothing in flight and FIFO empty.

## Operation
- Accept occurs when `req_valid && req_ready` at a rising edge. On that edge:
  - `fpu_op`, `fpu_rmode`, `fpu_opa` and `fpu_opb` load from the request.
  - The tag pipeline stage 1 loads {1, `req_tag`}.
- With no accept, the operand registers hold their values and stage 1 loads valid=0.
- Tag pipeline: LAT+1 stages, shifting every cycle. When the last stage is valid at an edge:
  - {`fpu_out`, `fpu_flags`, tag} are written into the FIFO at the tail.
  - The write is unconditional. Credits guarantee there is space.
- Credit counter `cnt` = in-flight count + FIFO occupancy, range 0..DEPTH.
  - Increments on accept.
  - Decrements on pop (`rsp_valid && rsp_ready`).
  - Is unchanged when both happen in the same cycle.
- `req_ready = (cnt != DEPTH)`, combinational from `cnt` only. It does not depend on `req_valid`.
- A pop and an accept in the same cycle at `cnt == DEPTH` is impossible, because `req_ready` is 0 in that cycle. The pop is taken, and `req_ready` rises on the next cycle.
- A FIFO write and a FIFO pop in the same cycle are both performed; occupancy is unchanged.
  - If the FIFO was empty and a write occurs, the entry appears at the head after the edge. No same-cycle bypass.
- Responses emerge in strict acceptance order.
- `drained = (cnt == 0)`.
- Pointer width is log2(DEPTH)+1; full/empty is decided by pointer MSB compare. Pointers wrap modulo 2·DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - all tag-pipe valids = 0, FIFO empty, `cnt` = 0;
  - `fpu_op` = 0, `fpu_rmode` = 0, `fpu_opa` = 0, `fpu_opb` = 0;
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_flags` = 0, `rsp_tag` = 0;
  - `req_ready` = 1, `drained` = 1.
- Latency: accept at edge E0.
  - FPU sees the operands from E0.
  - `fpu_out` is valid from E0+LAT and is captured at edge E0+LAT+1.
  - `rsp_valid` rises after E0+LAT+1, so acceptance to response is LAT+1 cycles.
- Throughput: one accept per cycle while credits remain.
  - With `rsp_ready` = 1, it is sustained indefinitely when DEPTH ≥ LAT+2.
  - Otherwise throughput is credit-limited.
- Reset mid-operation: all in-flight and buffered results are discarded, and no response is emitted for them. `req_ready` = 1 immediately after reset.
- `rsp_*` hold stable while `rsp_valid && !rsp_ready`.

## Test plan
- **Single add.** rmode=0, op=0, opa=0x40490FD0, opb=0x49753739, tag=5 → exactly 5 cycles later (LAT=4): `rsp_valid`, `rsp_data`=0x4975376B, `rsp_tag`=5, `rsp_flags[4]` (ine)=1, other flags 0.
- **Divide by zero.** op=3, opa=0x3F800000, opb=0x00000000 → `rsp_data`=0x7F800000, div_by_zero=1, inf=1.
- **Streaming.** 8 back-to-back requests, tags 0..7, with `rsp_ready`=1, DEPTH=8 → `req_ready` never drops; responses on 8 consecutive cycles with tags 0..7 in order.
- **Backpressure.** `rsp_ready`=0 with DEPTH=4 → `req_ready` falls after the 4th accept. Release `rsp_ready` for one cycle → exactly one pop, `req_ready`=1 the next cycle, and the next accept succeeds with ordering preserved.
- **Simultaneous events.** Simultaneous FIFO write and pop at occupancy 2 → occupancy stays 2, no entry lost or duplicated; `cnt` checked each cycle against a model.
- **Reset mid-flight.** Assert `rst_n`=0 for 1 cycle with 3 ops in flight and 1 buffered → `rsp_valid`=0, `drained`=1, `req_ready`=1, and no stale response appears within 10 cycles.
